// File: rtl/shifter_seq_if.sv
// Operation bus for shifter_seq: start/op/shamt/d_in request side and the
// registered data, carry and busy/done status returned by the shifter.
interface shifter_seq_if #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
);
  logic               start;
  logic [2:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   d_in;
  logic [WIDTH-1:0]   d_out;
  logic               carry;
  logic               busy;
  logic               done;
  logic [1:0]         state_dbg;

  // Handshake: start is accepted only while idle (busy=0, done=0) and op/shamt/d_in
  // are sampled on that same edge; the caller then waits for the one-cycle done
  // pulse. start raised while busy or done is dropped, never queued.
  modport master (
    output start, op, shamt, d_in,
    input  d_out, carry, busy, done, state_dbg
  );

  modport slave (
    input  start, op, shamt, d_in,
    output d_out, carry, busy, done, state_dbg
  );
endinterface

// File: rtl/shifter_seq.sv
// Multi-cycle shift register: LOAD/CLR/NOP in one cycle, shifts and rotates
// advance one bit per clock with a carry-out of the last bit moved.
module shifter_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input logic           clk,
  input logic           reset_n,
  shifter_seq_if.slave  bus
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               carry_q, carry_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_DONE;
          case (bus.op)
            OP_LOAD: begin
              data_d  = bus.d_in;
              carry_d = 1'b0;
            end
            OP_CLR: begin
              data_d  = '0;
              carry_d = 1'b0;
            end
            OP_NOP: ;
            default: begin
              // A zero-length shift completes like NOP, leaving data and carry intact.
              if (bus.shamt != '0) begin
                op_d    = bus.op;
                cnt_d   = bus.shamt;
                state_d = S_SHIFT;
              end
            end
          endcase
        end
      end
      S_SHIFT: begin
        case (op_q)
          OP_LSL: begin
            data_d  = {data_q[WIDTH-2:0], 1'b0};
            carry_d = data_q[WIDTH-1];
          end
          OP_LSR: begin
            data_d  = {1'b0, data_q[WIDTH-1:1]};
            carry_d = data_q[0];
          end
          OP_ASR: begin
            data_d  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            carry_d = data_q[0];
          end
          OP_ROL: begin
            data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            carry_d = data_q[WIDTH-1];
          end
          OP_ROR: begin
            data_d  = {data_q[0], data_q[WIDTH-1:1]};
            carry_d = data_q[0];
          end
          default: ;
        endcase
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.d_out     = data_q;
  assign bus.carry     = carry_q;
  assign bus.busy      = (state_q == S_SHIFT);
  assign bus.done      = (state_q == S_DONE);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Directed and random operations on shifter_seq, checked against an
// arithmetic model of each operation's final result, carry and latency.
module tb_shifter_seq;
  localparam int W  = 16;
  localparam int SW = 4;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] m_data;
  logic         m_carry;

  shifter_seq_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  shifter_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Final value after n single-bit steps, computed directly from the whole word.
  task automatic apply_model(input logic [2:0] op, input int n, input logic [W-1:0] din);
    logic [W-1:0] v;
    int k;
    v = m_data;
    k = n % W;
    case (op)
      3'd1: begin m_data = din; m_carry = 1'b0; end
      3'd7: begin m_data = '0;  m_carry = 1'b0; end
      3'd0: ;
      default: if (n > 0) begin
        case (op)
          3'd2: begin
            m_data  = (n >= W) ? '0 : W'(v << n);
            m_carry = (n <= W) ? v[W-n] : 1'b0;
          end
          3'd3: begin
            m_data  = (n >= W) ? '0 : (v >> n);
            m_carry = (n <= W) ? v[n-1] : 1'b0;
          end
          3'd4: begin
            m_data  = W'($signed(v) >>> n);
            m_carry = v[(n - 1 < W - 1) ? n - 1 : W - 1];
          end
          3'd5: begin
            m_data  = (k == 0) ? v : W'((v << k) | (v >> (W - k)));
            m_carry = m_data[0];
          end
          default: begin
            m_data  = (k == 0) ? v : W'((v >> k) | (v << (W - k)));
            m_carry = m_data[W-1];
          end
        endcase
      end
    endcase
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input int n,
                        input logic [W-1:0] din, input bit poke_clr);
    int lat, busy_cnt, exp_lat, exp_busy;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.shamt = SW'(n);
    bus.d_in  = din;
    apply_model(op, n, din);
    exp_busy = (op inside {3'd2, 3'd3, 3'd4, 3'd5, 3'd6}) ? n : 0;
    exp_lat  = exp_busy + 1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!bus.done && lat < 64) begin
      if (bus.busy) busy_cnt++;
      bus.op    = 3'($urandom_range(0, 7));
      bus.shamt = SW'($urandom);
      bus.d_in  = W'($urandom);
      bus.start = (poke_clr && lat == 2);
      if (poke_clr && lat == 2) bus.op = 3'd7;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, exp_busy);
    check({tag, " d_out"}, bus.d_out, m_data);
    check({tag, " carry"}, bus.carry, m_carry);
    check({tag, " busy_at_done"}, bus.busy, 1'b0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, bus.done, 1'b0);
  endtask

  initial begin
    int dones;
    logic [W-1:0] r;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.shamt = '0;
    bus.d_in  = '0;
    m_data    = '0;
    m_carry   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset d_out", bus.d_out, 16'h0000);
    check("reset carry", bus.carry, 1'b0);
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);

    run_op("load_a5c3", 3'd1, 0, 16'hA5C3, 1'b0);
    run_op("lsl4", 3'd2, 4, '0, 1'b0);
    check("lsl4 literal", bus.d_out, 16'h5C30);
    run_op("load_8001", 3'd1, 0, 16'h8001, 1'b0);
    run_op("asr15", 3'd4, 15, '0, 1'b0);
    check("asr15 literal", bus.d_out, 16'hFFFF);
    run_op("ror1", 3'd6, 1, '0, 1'b0);
    check("ror1 carry literal", bus.carry, 1'b1);
    run_op("load_8001b", 3'd1, 0, 16'h8001, 1'b0);
    run_op("rol1", 3'd5, 1, '0, 1'b0);
    check("rol1 literal", bus.d_out, 16'h0003);
    run_op("lsr0", 3'd3, 0, '0, 1'b0);
    check("lsr0 carry literal", bus.carry, 1'b1);

    r = W'($urandom);
    run_op("load_rand", 3'd1, 0, r, 1'b0);
    run_op("lsr8_clr_ignored", 3'd3, 8, '0, 1'b1);
    check("lsr8 literal", bus.d_out, r >> 8);
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("lsr8 extra_done", dones, 0);

    run_op("load_pre_reset", 3'd1, 0, 16'h1234, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd3;
    bus.shamt = SW'(10);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset d_out", bus.d_out, 16'h0000);
    check("async_reset carry", bus.carry, 1'b0);
    check("async_reset busy", bus.busy, 1'b0);
    check("async_reset done", bus.done, 1'b0);
    m_data  = '0;
    m_carry = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("async_reset no_done", dones, 0);
    run_op("load_post_reset", 3'd1, 0, 16'hC0DE, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)),
             int'($urandom_range(0, 15)), W'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shifter_seq.md
Name: shifter_seq

Overview:
- Parametrised, multi-cycle successor to the 8-bit shift register.
- Holds a WIDTH-bit register and runs LOAD, CLR, logical, arithmetic and rotate shifts by a run-time amount, one bit position per clock.
- Adds a start/busy/done handshake and a carry-out of the last bit shifted out.
- Used by datapath controllers that issue one operation at a time and wait for done.

Parameters:
- WIDTH, 16, data register width in bits (>= 2).
- SHAMT_W, 4, width of the shift-amount port. The maximum amount is 2^SHAMT_W-1 and may exceed WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation code; sampled with start.
- shamt  input  SHAMT_W  shift amount; sampled with start.
- d_in  input  WIDTH  load data; sampled with start when op=LOAD.
- d_out  output  WIDTH  shift register contents.
- carry  output  1  last bit shifted or rotated out.
- busy  output  1  high while a multi-cycle shift is in progress.
- done  output  1  one-cycle pulse when an accepted operation completes.

Behaviour:
- Reset (asynchronous, reset_n=0): d_out=0, carry=0, busy=0, done=0, state=IDLE, step counter=0. Reset mid-shift aborts the operation immediately; no done pulse follows.
- op codes:
  - 000 NOP
  - 001 LOAD
  - 010 LSL
  - 011 LSR
  - 100 ASR
  - 101 ROL
  - 110 ROR
  - 111 CLR
- States: IDLE, SHIFT, DONE.
- IDLE with start=1 at edge E0:
  - LOAD: d_out<=d_in, carry<=0, go to DONE.
  - CLR: d_out<=0, carry<=0, go to DONE.
  - NOP: no change, go to DONE.
  - Shift op with shamt=0: d_out and carry unchanged, go to DONE.
  - Shift op with shamt=N>0: latch op, counter<=N, go to SHIFT. No data change at E0.
- IDLE with start=0: hold all values.
- SHIFT, one step per edge; counter decrements each step:
  - LSL: d_out<={d_out[W-2:0],0}, carry<=d_out[W-1].
  - LSR: d_out<={0,d_out[W-1:1]}, carry<=d_out[0].
  - ASR: d_out<={d_out[W-1],d_out[W-1:1]}, carry<=d_out[0].
  - ROL: d_out<={d_out[W-2:0],d_out[W-1]}, carry<=d_out[W-1].
  - ROR: d_out<={d_out[0],d_out[W-1:1]}, carry<=d_out[0].
  - The step that brings the counter to 0 is the last; state goes to DONE on that edge.
- Latency:
  - Shift with N>0: updates on edges E1..EN; done high for the cycle after EN; busy high from after E0 through EN.
  - Start-to-done is N+1 cycles.
  - Single-cycle ops: done high the cycle after E0, busy never asserted.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE.
- start is ignored in SHIFT and DONE; no queuing. op, shamt and d_in are don't-care outside the accepting edge.
- N >= WIDTH is legal; the result is N single-bit steps:
  - LSL/LSR with N >= WIDTH give 0.
  - ASR with N >= WIDTH-1 gives all sign bits.
  - Rotates wrap modulo WIDTH.
- d_out is a registered output, stable throughout. Changes to the op/shamt inputs during SHIFT have no effect.

Test Plan (WIDTH=16, SHAMT_W=4):
- Reset then idle 3 cycles -> d_out=0x0000, carry=0, busy=0, done=0.
- LOAD d_in=0xA5C3; then LSL shamt=4 -> busy 4 cycles, done pulse 5 cycles after start, d_out=0x5C30, carry=0 (last bit out = bit 12 of 0xA5C3 = 0).
- LOAD 0x8001; ASR shamt=15 -> d_out=0xFFFF, carry=0. Then ROR shamt=1 -> d_out=0xFFFF, carry=1.
- LOAD 0x8001; ROL shamt=1 -> d_out=0x0003, carry=1. Then LSR shamt=0 -> done 1 cycle after start, d_out=0x0003, carry unchanged=1.
- During an LSR shamt=8, pulse start with op=CLR -> ignored. Final d_out=original>>8 and exactly one done pulse.
- Assert reset_n=0 mid-shift (step 3 of 10), asynchronously between edges -> outputs cleared immediately, no done pulse. After release, a new LOAD is accepted normally.
